// File: rtl/lab3_display_sched.sv
// Two-digit seven-segment scheduler: one shared hex decoder time-multiplexed across
// both digits, with key history updates committed only while the display is blanked.
module lab3_display_sched #(
    parameter int SHOW_CYCLES  = 48000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] digit_l,
    output logic [3:0] digit_r,
    output logic       overrun
);

    localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        BLANK_R = 2'd0,
        SHOW_L  = 2'd1,
        BLANK_L = 2'd2,
        SHOW_R  = 2'd3
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] glyph;
        case (value)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            4'hF:    glyph = 7'b0001110;
            default: glyph = 7'b1111111;
        endcase
        return glyph;
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] w_phase_next;
    logic             w_phase_last;
    logic             w_enter_blank;
    logic             w_commit;
    logic [3:0]       w_dec_in;
    logic [6:0]       w_dec_out;
    logic [1:0]       r_an;
    logic [1:0]       w_an_next;
    logic [6:0]       r_seg;
    logic [6:0]       w_seg_next;
    logic [3:0]       r_digit_l;
    logic [3:0]       r_digit_r;
    logic [3:0]       r_pending;
    logic             r_pending_v;
    logic             r_overrun;

    // Next-state, phase counter and next registered display outputs
    always_comb begin
        w_state_next  = r_state;
        w_phase_next  = r_phase + CNT_W'(1);
        w_phase_last  = 1'b0;
        w_enter_blank = 1'b0;
        w_an_next     = r_an;
        w_seg_next    = r_seg;

        case (r_state)
            SHOW_L, SHOW_R: w_phase_last = (r_phase == SHOW_LAST);
            BLANK_L, BLANK_R: w_phase_last = (r_phase == BLANK_LAST);
            default: w_phase_last = 1'b1;
        endcase

        if (w_phase_last) begin
            w_phase_next = '0;
            case (r_state)
                BLANK_R: w_state_next = SHOW_L;
                SHOW_L:  w_state_next = BLANK_L;
                BLANK_L: w_state_next = SHOW_R;
                SHOW_R:  w_state_next = BLANK_R;
                default: w_state_next = BLANK_R;
            endcase
            w_enter_blank = (r_state == SHOW_L) || (r_state == SHOW_R);
        end else begin
            w_state_next  = r_state;
            w_enter_blank = 1'b0;
        end

        // seg is latched at SHOW entry only; digits cannot change until the next blank
        if (w_phase_last) begin
            case (w_state_next)
                SHOW_L: begin
                    w_an_next  = 2'b01;
                    w_seg_next = w_dec_out;
                end
                SHOW_R: begin
                    w_an_next  = 2'b10;
                    w_seg_next = w_dec_out;
                end
                default: begin
                    w_an_next  = 2'b11;
                    w_seg_next = 7'b1111111;
                end
            endcase
        end else begin
            w_an_next  = r_an;
            w_seg_next = r_seg;
        end
    end

    // Shared decoder input select and commit qualification
    always_comb begin
        w_dec_in = r_digit_r;
        if (w_state_next == SHOW_L) begin
            w_dec_in = r_digit_l;
        end else begin
            w_dec_in = r_digit_r;
        end
        w_dec_out = seg_decode(w_dec_in);
        w_commit  = w_enter_blank && r_pending_v;
    end

    // Mux FSM state, phase counter and registered anode/segment drive
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            r_state <= BLANK_R;
            r_phase <= '0;
            r_an    <= 2'b11;
            r_seg   <= 7'b1111111;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_an    <= w_an_next;
            r_seg   <= w_seg_next;
        end
    end

    // Key capture, blank-window commit of the digit history, sticky overrun
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            r_digit_l   <= 4'h0;
            r_digit_r   <= 4'h0;
            r_pending   <= 4'h0;
            r_pending_v <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_commit) begin
                r_digit_l <= r_digit_r;
                r_digit_r <= r_pending;
            end
            // A key landing on a commit edge is not an overrun: the old value leaves this edge
            if (key_valid) begin
                r_pending   <= key_code;
                r_pending_v <= 1'b1;
                if (r_pending_v && !w_commit) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_commit) begin
                r_pending_v <= 1'b0;
            end
        end
    end

    assign seg     = r_seg;
    assign an      = r_an;
    assign digit_l = r_digit_l;
    assign digit_r = r_digit_r;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_lab3_display_sched.sv
// Self-checking bench for lab3_display_sched: edge-count position model of the display
// cycle plus a key-history model, compared every cycle against the DUT.
module tb_lab3_display_sched;

    localparam int S = 8;
    localparam int B = 2;
    localparam int P = 2 * (S + B);
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [17:0] RESET_VEC = {2'b11, 7'b1111111, 4'h0, 4'h0, 1'b0};

    logic       int_osc = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] digit_l;
    logic [3:0] digit_r;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    int         m_k;
    logic [3:0] m_l, m_r, m_pend;
    logic       m_pv, m_ovr;

    wire [17:0] dut_vec = {an, seg, digit_l, digit_r, overrun};

    lab3_display_sched #(.SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .int_osc  (int_osc),
        .reset    (reset),
        .key_valid(key_valid),
        .key_code (key_code),
        .seg      (seg),
        .an       (an),
        .digit_l  (digit_l),
        .digit_r  (digit_r),
        .overrun  (overrun)
    );

    always #5 int_osc = ~int_osc;

    task automatic model_reset();
        m_k = 0; m_l = 4'h0; m_r = 4'h0; m_pend = 4'h0; m_pv = 1'b0; m_ovr = 1'b0;
    endtask

    // Position within the 20-edge period since reset release decides the display phase
    function automatic logic [17:0] model_out();
        int p;
        logic [1:0] a;
        logic [6:0] s;
        p = m_k % P;
        if (p < B) begin
            a = 2'b11; s = 7'b1111111;
        end else if (p < B + S) begin
            a = 2'b01; s = GLYPH[m_l];
        end else if (p < 2 * B + S) begin
            a = 2'b11; s = 7'b1111111;
        end else begin
            a = 2'b10; s = GLYPH[m_r];
        end
        return {a, s, m_l, m_r, m_ovr};
    endfunction

    task automatic step(input logic kv, input logic [3:0] kc);
        int  p;
        bit  commit, ovr_hit;
        key_valid = kv;
        key_code  = kc;
        @(posedge int_osc);
        m_k++;
        p       = m_k % P;
        commit  = ((p == B + S) || (p == 0)) && m_pv;
        ovr_hit = kv && m_pv && !commit;
        if (commit) begin
            m_l = m_r; m_r = m_pend; m_pv = 1'b0;
        end
        if (kv) begin
            m_pend = kc; m_pv = 1'b1;
        end
        if (ovr_hit) m_ovr = 1'b1;
        #1;
        key_valid = 1'b0;
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < P && (m_k % P) != target; i++) step(1'b0, 4'h0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        key_valid = 1'b0;
        @(posedge int_osc);
        @(negedge int_osc);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        #1;
        n_tests++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec, RESET_VEC);
        end
        @(posedge int_osc);
        @(negedge int_osc);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'h0);
            n_tests++;
            if (dut_vec !== model_out()) begin
                n_fail++; $display("FAIL idle cyc %0d: got %h expected %h", i, dut_vec, model_out());
            end
        end
    endtask

    task automatic test_single_key();
        run_until(B + 2);
        step(1'b1, 4'h5);
        for (int i = 0; i < P && (m_k % P) != 2 * B + S + 1; i++) begin
            step(1'b0, 4'h0);
            n_tests++;
            if (dut_vec !== model_out()) begin
                n_fail++; $display("FAIL single_key cyc %0d: got %h expected %h", i, dut_vec, model_out());
            end
            if ((m_k % P) == B + S) begin
                n_tests++;
                if (digit_r !== 4'h5 || digit_l !== 4'h0) begin
                    n_fail++; $display("FAIL single_key_commit: got l=%h r=%h expected l=0 r=5", digit_l, digit_r);
                end
            end
        end
        n_tests++;
        if (seg !== 7'b0010010) begin
            n_fail++; $display("FAIL single_key_seg: got %b expected 0010010", seg);
        end
    endtask

    task automatic test_two_keys();
        logic [3:0] keys [2];
        keys[0] = 4'h1; keys[1] = 4'hA;
        for (int k = 0; k < 2; k++) begin
            run_until(B + 1);
            step(1'b1, keys[k]);
            for (int i = 0; i < P; i++) begin
                step(1'b0, 4'h0);
                n_tests++;
                if (dut_vec !== model_out()) begin
                    n_fail++; $display("FAIL two_keys k%0d cyc %0d: got %h expected %h", k, i, dut_vec, model_out());
                end
            end
        end
        n_tests++;
        if (digit_l !== 4'h1 || digit_r !== 4'hA || seg !== 7'b1111001) begin
            n_fail++; $display("FAIL two_keys_left: got l=%h r=%h seg=%b expected l=1 r=a seg=1111001", digit_l, digit_r, seg);
        end
        run_until(2 * B + S + 1);
        n_tests++;
        if (seg !== 7'b0001000 || an !== 2'b10) begin
            n_fail++; $display("FAIL two_keys_right: got seg=%b an=%b expected seg=0001000 an=10", seg, an);
        end
    endtask

    task automatic test_overrun();
        run_until(B + 1);
        step(1'b1, 4'h3);
        step(1'b1, 4'h7);
        for (int i = 0; i < 2 * P; i++) begin
            step(1'b0, 4'h0);
            n_tests++;
            if (dut_vec !== model_out() || seg === 7'b0110000) begin
                n_fail++; $display("FAIL overrun cyc %0d: got %h expected %h", i, dut_vec, model_out());
            end
        end
        n_tests++;
        if (digit_r !== 4'h7 || digit_l !== 4'hA || overrun !== 1'b1) begin
            n_fail++; $display("FAIL overrun_final: got l=%h r=%h ovr=%b expected l=a r=7 ovr=1", digit_l, digit_r, overrun);
        end
    endtask

    task automatic test_commit_collision();
        apply_reset();
        run_until(B + 2);
        step(1'b1, 4'h2);
        run_until(B + S - 1);
        step(1'b1, 4'h9);
        n_tests++;
        if (digit_r !== 4'h2 || overrun !== 1'b0 || dut_vec !== model_out()) begin
            n_fail++; $display("FAIL collision_edge: got r=%h ovr=%b expected r=2 ovr=0", digit_r, overrun);
        end
        for (int i = 0; i < P && (m_k % P) != 0; i++) begin
            step(1'b0, 4'h0);
            n_tests++;
            if (dut_vec !== model_out()) begin
                n_fail++; $display("FAIL collision cyc %0d: got %h expected %h", i, dut_vec, model_out());
            end
        end
        n_tests++;
        if (digit_l !== 4'h2 || digit_r !== 4'h9 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL collision_blank_r: got l=%h r=%h ovr=%b expected l=2 r=9 ovr=0", digit_l, digit_r, overrun);
        end
    endtask

    task automatic test_random();
        logic       kv;
        logic [3:0] kc;
        for (int i = 0; i < 400; i++) begin
            kv = ($urandom_range(0, 9) == 0);
            kc = 4'($urandom_range(0, 15));
            step(kv, kc);
            n_tests++;
            if (dut_vec !== model_out()) begin
                n_fail++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec, model_out());
            end
        end
    endtask

    task automatic test_reset_mid();
        run_until(2 * B + S + 2);
        step(1'b1, 4'hC);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_mid: got %h expected %h", dut_vec, RESET_VEC);
        end
        @(posedge int_osc);
        @(negedge int_osc);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < P + B; i++) begin
            step(1'b0, 4'h0);
            n_tests++;
            if (dut_vec !== model_out()) begin
                n_fail++; $display("FAIL reset_restart cyc %0d: got %h expected %h", i, dut_vec, model_out());
            end
            if (m_k == B) begin
                n_tests++;
                if (an !== 2'b01) begin
                    n_fail++; $display("FAIL reset_restart_order: got an=%b expected 01", an);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_key();
        test_two_keys();
        test_overrun();
        test_commit_collision();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
